// File: rtl/locked_reg_arbiter.sv
// Arbitrated, lock-aware access front end for a small bank of configuration registers.
// A trusted port may always write; untrusted writes to locked registers are rejected and counted.
module locked_reg_arbiter #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 3
) (
  input  logic                         Clk,
  input  logic                         resetn,
  input  logic                         t_req,
  input  logic                         t_we,
  input  logic [ADDR_W-1:0]            t_addr,
  input  logic [DATA_W-1:0]            t_wdata,
  output logic                         t_ack,
  output logic                         t_err,
  output logic [DATA_W-1:0]            t_rdata,
  input  logic                         u_req,
  input  logic                         u_we,
  input  logic [ADDR_W-1:0]            u_addr,
  input  logic [DATA_W-1:0]            u_wdata,
  output logic                         u_ack,
  output logic                         u_err,
  output logic [DATA_W-1:0]            u_rdata,
  input  logic [NUM_REGS-1:0]          lock_set,
  output logic [NUM_REGS-1:0]          lock_q,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [7:0]                   viol_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWNER_U = 1'b0,
    OWNER_T = 1'b1
  } owner_e;

  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  state_e              state_q, state_d;
  owner_e              cur_owner, last_owner;
  logic                cur_we;
  logic [ADDR_W-1:0]   cur_addr;
  logic [DATA_W-1:0]   cur_wdata;

  logic                grant;
  logic                grant_trusted;
  logic                in_range;
  logic                eff_lock;
  logic [DATA_W-1:0]   sel_rdata;
  logic                exec_write;
  logic                exec_err;
  logic [DATA_W-1:0]   exec_rdata;
  logic                viol_inc;

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Decode the latched address; a lock requested this very cycle already counts.
  always_comb begin
    in_range  = ({1'b0, cur_addr} < NUM_REGS_W);
    eff_lock  = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cur_addr == ADDR_W'(i)) begin
        eff_lock  = lock_q[i] | lock_set[i];
        sel_rdata = reg_q[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant         = 1'b0;
    grant_trusted = 1'b0;
    exec_write    = 1'b0;
    exec_err      = 1'b0;
    exec_rdata    = '0;
    viol_inc      = 1'b0;
    case (state_q)
      IDLE: begin
        if (t_req || u_req) begin
          grant   = 1'b1;
          state_d = EXEC;
          if (t_req && u_req) grant_trusted = (last_owner == OWNER_U);
          else                grant_trusted = t_req;
        end
      end
      EXEC: begin
        state_d = DONE;
        if (!in_range) begin
          exec_err = 1'b1;
        end else if (!cur_we) begin
          exec_rdata = sel_rdata;
        end else if ((cur_owner == OWNER_T) || !eff_lock) begin
          exec_write = 1'b1;
        end else begin
          exec_err = 1'b1;
          viol_inc = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      cur_owner  <= OWNER_U;
      last_owner <= OWNER_U;
      cur_we     <= 1'b0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
    end else if (grant) begin
      cur_owner  <= grant_trusted ? OWNER_T : OWNER_U;
      last_owner <= grant_trusted ? OWNER_T : OWNER_U;
      cur_we     <= grant_trusted ? t_we    : u_we;
      cur_addr   <= grant_trusted ? t_addr  : u_addr;
      cur_wdata  <= grant_trusted ? t_wdata : u_wdata;
    end
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      reg_q    <= '0;
      lock_q   <= '0;
      viol_cnt <= '0;
    end else begin
      lock_q <= lock_q | lock_set;
      if (exec_write) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (cur_addr == ADDR_W'(i)) reg_q[i*DATA_W +: DATA_W] <= cur_wdata;
        end
      end
      if (viol_inc && (viol_cnt != 8'hFF)) viol_cnt <= viol_cnt + 8'd1;
    end
  end

  // The non-owner port keeps its previous err/rdata; only ack is pulsed.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      t_ack   <= 1'b0;
      t_err   <= 1'b0;
      t_rdata <= '0;
      u_ack   <= 1'b0;
      u_err   <= 1'b0;
      u_rdata <= '0;
    end else begin
      t_ack <= 1'b0;
      u_ack <= 1'b0;
      if (state_q == EXEC) begin
        if (cur_owner == OWNER_T) begin
          t_ack   <= 1'b1;
          t_err   <= exec_err;
          t_rdata <= exec_rdata;
        end else begin
          u_ack   <= 1'b1;
          u_err   <= exec_err;
          u_rdata <= exec_rdata;
        end
      end
    end
  end

endmodule
